// File: rtl/ras_pkg.sv
// Shared types and constants for the return address stack.
// Holds the PC width, the stack geometry, and the count clamp helper.
package ras_pkg;

    localparam int RAS_ENTRIES     = 16;
    localparam int LOG_RAS_ENTRIES = $clog2(RAS_ENTRIES);

    typedef logic [37:0]                PC38_t;
    typedef logic [LOG_RAS_ENTRIES-1:0] RAS_idx_t;
    typedef logic [LOG_RAS_ENTRIES:0]   RAS_cnt_t;

    localparam PC38_t    INIT_PC38   = 38'h0;
    localparam RAS_cnt_t RAS_CNT_MAX = RAS_cnt_t'(RAS_ENTRIES);

    // A restored count above capacity is illegal; saturate it so the stack stays consistent.
    function automatic RAS_cnt_t clamp_cnt(input RAS_cnt_t cnt);
        return (cnt > RAS_CNT_MAX) ? RAS_CNT_MAX : cnt;
    endfunction

endpackage

// File: rtl/ras.sv
// Circular return address stack feeding fetch's next-PC selection.
// Pushes link addresses, pops on returns, and restores pointer/count from backend checkpoints.
module ras
    import ras_pkg::*;
(
    input  logic     CLK,
    input  logic     nRST,
    input  logic     link_valid,
    input  PC38_t    link_pc38,
    input  logic     ret_valid,
    output PC38_t    ret_pc38,
    output RAS_idx_t ras_index,
    output RAS_cnt_t ras_count,
    output logic     ras_empty,
    input  logic     update_valid,
    input  RAS_idx_t update_ras_index,
    input  RAS_cnt_t update_ras_count
);

    PC38_t    r_entries [RAS_ENTRIES];
    RAS_idx_t r_sp;
    RAS_cnt_t r_cnt;

    RAS_idx_t w_top_idx;
    RAS_idx_t w_sp_next;
    RAS_cnt_t w_cnt_next;
    logic     w_wr_en;
    RAS_idx_t w_wr_idx;
    logic     w_cnt_zero;

    // The pointer width equals log2(depth), so sp-1 wraps 0 -> RAS_ENTRIES-1 by itself.
    assign w_top_idx  = r_sp - RAS_idx_t'(1);
    assign w_cnt_zero = (r_cnt == '0);

    assign ret_pc38  = r_entries[w_top_idx];
    assign ras_index = r_sp;
    assign ras_count = r_cnt;
    assign ras_empty = w_cnt_zero;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_sp_next  = r_sp;
        w_cnt_next = r_cnt;
        w_wr_en    = 1'b0;
        w_wr_idx   = r_sp;

        if (update_valid) begin
            w_sp_next  = update_ras_index;
            w_cnt_next = clamp_cnt(update_ras_count);
        end else if (link_valid && ret_valid && !w_cnt_zero) begin
            w_wr_en  = 1'b1;
            w_wr_idx = w_top_idx;
        end else if (link_valid) begin
            w_wr_en    = 1'b1;
            w_wr_idx   = r_sp;
            w_sp_next  = r_sp + RAS_idx_t'(1);
            w_cnt_next = (r_cnt == RAS_CNT_MAX) ? r_cnt : r_cnt + RAS_cnt_t'(1);
        end else if (ret_valid && !w_cnt_zero) begin
            w_sp_next  = w_top_idx;
            w_cnt_next = r_cnt - RAS_cnt_t'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_sp  <= '0;
            r_cnt <= '0;
        end else begin
            r_sp  <= w_sp_next;
            r_cnt <= w_cnt_next;
        end
    end

    // NOTE: the entries are reset because fetch may consume a stale top while empty and must see INIT_PC38, not X.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                r_entries[i] <= INIT_PC38;
            end
        end else if (w_wr_en) begin
            r_entries[w_wr_idx] <= link_pc38;
        end
    end

    a_update_count_legal: assert property (
        @(posedge CLK) disable iff (!nRST) update_valid |-> (update_ras_count <= RAS_CNT_MAX)
    );

endmodule

// File: tb/tb_ras.sv
// Directed self-checking bench for the return address stack.
// Each task drives one scenario and compares outputs against hand-computed values.
module tb_ras;
    import ras_pkg::*;

    logic     CLK;
    logic     nRST;
    logic     link_valid;
    PC38_t    link_pc38;
    logic     ret_valid;
    PC38_t    ret_pc38;
    RAS_idx_t ras_index;
    RAS_cnt_t ras_count;
    logic     ras_empty;
    logic     update_valid;
    RAS_idx_t update_ras_index;
    RAS_cnt_t update_ras_count;

    int n_checks = 0;
    int n_fail   = 0;

    ras dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .link_valid       (link_valid),
        .link_pc38        (link_pc38),
        .ret_valid        (ret_valid),
        .ret_pc38         (ret_pc38),
        .ras_index        (ras_index),
        .ras_count        (ras_count),
        .ras_empty        (ras_empty),
        .update_valid     (update_valid),
        .update_ras_index (update_ras_index),
        .update_ras_count (update_ras_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Applies one cycle of inputs, lets the rising edge pass, samples point is 1ns later.
    task automatic cycle(input logic lv, input PC38_t pc, input logic rv,
                         input logic uv, input RAS_idx_t ui, input RAS_cnt_t uc);
        link_valid       = lv;
        link_pc38        = pc;
        ret_valid        = rv;
        update_valid     = uv;
        update_ras_index = ui;
        update_ras_count = uc;
        @(posedge CLK);
        #1;
        link_valid   = 1'b0;
        ret_valid    = 1'b0;
        update_valid = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
        n_checks++;
        if (ret_pc38 !== 38'h0) begin
            $display("FAIL reset_ret_pc38: got %h want %h", ret_pc38, 38'h0); n_fail++;
        end
        n_checks++;
        if (ras_index !== 4'd0) begin
            $display("FAIL reset_index: got %0d want 0", ras_index); n_fail++;
        end
        n_checks++;
        if (ras_count !== 5'd0) begin
            $display("FAIL reset_count: got %0d want 0", ras_count); n_fail++;
        end
        n_checks++;
        if (ras_empty !== 1'b1) begin
            $display("FAIL reset_empty: got %b want 1", ras_empty); n_fail++;
        end
    endtask

    task automatic test_push_pop();
        PC38_t exp_ret [3] = '{38'h200, 38'h100, 38'h0};
        cycle(1'b1, 38'h100, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 38'h200, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 38'h300, 1'b0, 1'b0, '0, '0);
        n_checks++;
        if (ret_pc38 !== 38'h300 || ras_index !== 4'd3 || ras_count !== 5'd3 || ras_empty !== 1'b0) begin
            $display("FAIL push3: got ret=%h idx=%0d cnt=%0d empty=%b want ret=300 idx=3 cnt=3 empty=0",
                     ret_pc38, ras_index, ras_count, ras_empty);
            n_fail++;
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, '0, '0);
            n_checks++;
            if (ret_pc38 !== exp_ret[i] || ras_count !== RAS_cnt_t'(2 - i)) begin
                $display("FAIL pop%0d: got ret=%h cnt=%0d want ret=%h cnt=%0d",
                         i, ret_pc38, ras_count, exp_ret[i], 2 - i);
                n_fail++;
            end
        end
        n_checks++;
        if (ras_index !== 4'd0 || ras_empty !== 1'b1) begin
            $display("FAIL pop_empty: got idx=%0d empty=%b want idx=0 empty=1", ras_index, ras_empty);
            n_fail++;
        end
    endtask

    task automatic test_overflow();
        for (int v = 1; v <= 17; v++) begin
            cycle(1'b1, PC38_t'(v), 1'b0, 1'b0, '0, '0);
        end
        n_checks++;
        if (ras_count !== 5'd16 || ras_index !== 4'd1 || ret_pc38 !== 38'h11) begin
            $display("FAIL overflow: got cnt=%0d idx=%0d ret=%h want cnt=16 idx=1 ret=11",
                     ras_count, ras_index, ret_pc38);
            n_fail++;
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (ret_pc38 !== PC38_t'(17 - i)) begin
                $display("FAIL overflow_pop%0d: got %h want %h", i, ret_pc38, PC38_t'(17 - i));
                n_fail++;
            end
            cycle(1'b0, '0, 1'b1, 1'b0, '0, '0);
        end
        n_checks++;
        if (ras_count !== 5'd0 || ras_index !== 4'd1 || ret_pc38 !== 38'h11) begin
            $display("FAIL overflow_drain: got cnt=%0d idx=%0d ret=%h want cnt=0 idx=1 ret=11",
                     ras_count, ras_index, ret_pc38);
            n_fail++;
        end
    endtask

    task automatic test_underflow();
        cycle(1'b0, '0, 1'b1, 1'b0, '0, '0);
        n_checks++;
        if (ras_count !== 5'd0 || ras_index !== 4'd1 || ret_pc38 !== 38'h11 || ras_empty !== 1'b1) begin
            $display("FAIL underflow: got cnt=%0d idx=%0d ret=%h empty=%b want cnt=0 idx=1 ret=11 empty=1",
                     ras_count, ras_index, ret_pc38, ras_empty);
            n_fail++;
        end
    endtask

    task automatic test_coroutine();
        cycle(1'b0, '0, 1'b0, 1'b1, 4'd0, 5'd0);
        // link+ret with an empty stack behaves as a plain push.
        cycle(1'b1, 38'hA, 1'b1, 1'b0, '0, '0);
        n_checks++;
        if (ras_index !== 4'd1 || ras_count !== 5'd1 || ret_pc38 !== 38'hA) begin
            $display("FAIL linkret_empty: got idx=%0d cnt=%0d ret=%h want idx=1 cnt=1 ret=a",
                     ras_index, ras_count, ret_pc38);
            n_fail++;
        end
        cycle(1'b1, 38'hB, 1'b0, 1'b0, '0, '0);
        link_valid = 1'b1;
        link_pc38  = 38'hC;
        ret_valid  = 1'b1;
        #1;
        n_checks++;
        if (ret_pc38 !== 38'hB) begin
            $display("FAIL coroutine_same_cycle: got %h want b", ret_pc38); n_fail++;
        end
        @(posedge CLK);
        #1;
        link_valid = 1'b0;
        ret_valid  = 1'b0;
        n_checks++;
        if (ret_pc38 !== 38'hC || ras_count !== 5'd2 || ras_index !== 4'd2) begin
            $display("FAIL coroutine_after: got ret=%h cnt=%0d idx=%0d want ret=c cnt=2 idx=2",
                     ret_pc38, ras_count, ras_index);
            n_fail++;
        end
    endtask

    task automatic test_checkpoint();
        cycle(1'b0, '0, 1'b0, 1'b1, 4'd0, 5'd0);
        cycle(1'b1, 38'hA, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 38'hB, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 38'hD, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 38'hE, 1'b0, 1'b0, '0, '0);
        n_checks++;
        if (ras_index !== 4'd4 || ret_pc38 !== 38'hE) begin
            $display("FAIL ckpt_pre: got idx=%0d ret=%h want idx=4 ret=e", ras_index, ret_pc38); n_fail++;
        end
        cycle(1'b1, 38'hF, 1'b0, 1'b1, 4'd2, 5'd2);
        n_checks++;
        if (ras_index !== 4'd2 || ras_count !== 5'd2 || ret_pc38 !== 38'hB) begin
            $display("FAIL ckpt_restore: got idx=%0d cnt=%0d ret=%h want idx=2 cnt=2 ret=b",
                     ras_index, ras_count, ret_pc38);
            n_fail++;
        end
        // Slot 4 still holds 0x5 from the overflow fill unless the dropped push of 0xF leaked in.
        cycle(1'b0, '0, 1'b0, 1'b1, 4'd5, 5'd5);
        n_checks++;
        if (ret_pc38 !== 38'h5 || ras_count !== 5'd5) begin
            $display("FAIL ckpt_push_dropped: got ret=%h cnt=%0d want ret=5 cnt=5", ret_pc38, ras_count);
            n_fail++;
        end
    endtask

    task automatic test_async_reset();
        @(negedge CLK);
        link_valid = 1'b1;
        link_pc38  = 38'h77;
        #2;
        nRST = 1'b0;
        #1;
        n_checks++;
        if (ras_index !== 4'd0 || ras_count !== 5'd0 || ras_empty !== 1'b1 || ret_pc38 !== 38'h0) begin
            $display("FAIL async_reset: got idx=%0d cnt=%0d empty=%b ret=%h want idx=0 cnt=0 empty=1 ret=0",
                     ras_index, ras_count, ras_empty, ret_pc38);
            n_fail++;
        end
        @(posedge CLK);
        #1;
        n_checks++;
        if (ras_index !== 4'd0 || ras_count !== 5'd0 || ret_pc38 !== 38'h0) begin
            $display("FAIL reset_hold_drops_push: got idx=%0d cnt=%0d ret=%h want idx=0 cnt=0 ret=0",
                     ras_index, ras_count, ret_pc38);
            n_fail++;
        end
        link_valid = 1'b0;
        nRST       = 1'b1;
        cycle(1'b1, 38'h123, 1'b0, 1'b0, '0, '0);
        n_checks++;
        if (ras_index !== 4'd1 || ras_count !== 5'd1 || ret_pc38 !== 38'h123) begin
            $display("FAIL post_reset_push: got idx=%0d cnt=%0d ret=%h want idx=1 cnt=1 ret=123",
                     ras_index, ras_count, ret_pc38);
            n_fail++;
        end
    endtask

    initial begin
        nRST             = 1'b0;
        link_valid       = 1'b0;
        link_pc38        = '0;
        ret_valid        = 1'b0;
        update_valid     = 1'b0;
        update_ras_index = '0;
        update_ras_count = '0;
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_coroutine();
        test_checkpoint();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ras.md
Name: ras

Overview:
- Return address stack for the fetch predictor stage. It supplies the predicted return PC38 for BTB_ACTION_RET/RET_L hits and pushes link addresses for JUMP_L/RET_L/INDIRECT_L hits.
- Fetch sits directly downstream. It selects ret_pc38 as one of its next-PC38 candidates.
- The backend restores the stack pointer and count from a checkpointed snapshot on a mispredict or restart.
- The block is a 1-wide circular stack: it overwrites the oldest entry on overflow and ignores pops when the count is zero.

Parameters:
- RAS_ENTRIES, 16, number of stack entries; must be a power of 2.
- LOG_RAS_ENTRIES, $clog2(RAS_ENTRIES), width of the stack pointer.
- INIT_PC38, 38'h0, reset value of every entry.

Ports:
- CLK  input  1  core clock
- nRST  input  1  asynchronous active-low reset
- link_valid  input  1  push request this cycle
- link_pc38  input  38  return address to push (PC38_t)
- ret_valid  input  1  pop request this cycle
- ret_pc38  output  38  current top-of-stack entry (combinational read)
- ras_index  output  LOG_RAS_ENTRIES  current stack pointer; next write slot (RAS_idx_t)
- ras_count  output  LOG_RAS_ENTRIES+1  valid-entry count, 0..RAS_ENTRIES (RAS_cnt_t)
- ras_empty  output  1  ras_count == 0
- update_valid  input  1  restore request from the backend
- update_ras_index  input  LOG_RAS_ENTRIES  restored stack pointer
- update_ras_count  input  LOG_RAS_ENTRIES+1  restored count

Behaviour:
- State:
  - entry array [RAS_ENTRIES] of PC38_t in flops.
  - sp (RAS_idx_t).
  - cnt (RAS_cnt_t).
- Reset (nRST low, asynchronous):
  - sp=0, cnt=0, every entry=INIT_PC38.
  - Outputs after reset: ret_pc38=INIT_PC38, ras_index=0, ras_count=0, ras_empty=1.
  - Reset mid-operation drops any same-cycle op.
- ret_pc38 = entry[sp-1] at all times, with modulo RAS_ENTRIES wrap.
  - It is valid in the same cycle as ret_valid; zero latency.
  - When empty it returns the stale entry; fetch treats that prediction as best effort.
- ras_index, ras_count and ras_empty are registered state. The fetch checkpoint logic captures them alongside the GHR.
- All updates take effect on the rising edge of CLK. Priority order:
  1. update_valid (takes priority over everything):
     - sp <= update_ras_index; cnt <= update_ras_count.
     - Entries are unchanged.
     - link_valid and ret_valid in the same cycle are ignored.
  2. link_valid & ret_valid & cnt!=0 (coroutine, RET_L):
     - entry[sp-1] <= link_pc38.
     - sp and cnt are unchanged.
     - ret_pc38 this cycle shows the old top.
  3. link_valid & ret_valid & cnt==0: behaves as a push only.
  4. link_valid only (push):
     - entry[sp] <= link_pc38; sp <= sp+1 (wraps 15->0).
     - cnt <= min(cnt+1, RAS_ENTRIES).
     - At cnt==RAS_ENTRIES the oldest entry is overwritten silently and cnt stays saturated.
  5. ret_valid only (pop):
     - If cnt!=0: sp <= sp-1 (wraps 0->15), cnt <= cnt-1.
     - If cnt==0: no state change (underflow ignored).
- update_ras_count > RAS_ENTRIES is illegal input. An assertion flags it; the RTL clamps it to RAS_ENTRIES.
- No backpressure: every op completes in one cycle and there is no stall output.

Decomposition:
- corep already provides PC38_t, INIT_PC38, RAS_ENTRIES, LOG_RAS_ENTRIES, RAS_idx_t and RAS_cnt_t; nothing new is added.
- No sub-module: the entry array is a flop array inside ras.
- The next-sp/next-cnt logic is one combinational block feeding flops.

Test Plan:
- Reset, then idle → ret_pc38=0, ras_index=0, ras_count=0, ras_empty=1.
- Push 0x100, 0x200, 0x300 on consecutive cycles:
  - ret_pc38=0x300, ras_index=3, ras_count=3.
  - Then pop three times → ret_pc38 reads 0x200, 0x100, 0 after each edge; ras_count=0.
- Push 17 values 0x1..0x11 → ras_count saturates at 16 and ras_index=1.
  - 16 pops return 0x11 down to 0x2; the 17th pop is ignored and count stays 0.
- Pop with ras_count=0 → ras_index, ras_count and entries unchanged; ret_pc38 unchanged.
- With stack {0xA,0xB}, assert link_valid=1, link_pc38=0xC and ret_valid=1:
  - ret_pc38=0xB in that cycle.
  - Afterwards top=0xC, ras_count=2, ras_index=2.
- Checkpoint (index=2, count=2), push 0xD and 0xE, then assert update_valid with the checkpoint while a push of 0xF is also asserted:
  - ras_index=2, ras_count=2, ret_pc38=0xB; the push of 0xF is dropped.
  - Assert nRST low mid-sequence → state returns to reset values asynchronously.
